// File: rtl/branch_history_tracker_pkg.sv
// Shared types and constants for the branch history tracker slice.
//   checkpoint_t        : snapshot pushed into checkpoint_buffer per predicted branch
//   CHECKPOINT_ID_WIDTH : width of a checkpoint id
//   COMMIT_WIDTH        : number of commit slots retiring per cycle
//   GHR_W / LHR_W       : global / local history widths
package branch_history_tracker_pkg;

    localparam int CHECKPOINT_ID_WIDTH = 3;
    localparam int COMMIT_WIDTH        = 4;
    localparam int GHR_W               = 16;
    localparam int LHR_W               = 16;
    localparam int RAT_ENTRIES         = 32;

    typedef struct packed {
        logic [RAT_ENTRIES-1:0] rat_phy_map_table_valid;
        logic [RAT_ENTRIES-1:0] rat_phy_map_table_visible;
        logic [GHR_W-1:0]       global_history;
        logic [LHR_W-1:0]       local_history;
    } checkpoint_t;

    typedef checkpoint_t ckpt_t;

endpackage

// File: rtl/branch_history_tracker_if.sv
// Fetch <-> branch history tracker handshake.
//   master : fetch side (drives branch valid/taken/pc, receives ready and histories)
//   slave  : tracker side
interface branch_history_tracker_if;
    import branch_history_tracker_pkg::*;

    logic                           fetch_bht_branch_valid;
    logic                           fetch_bht_branch_taken;
    logic [31:0]                    fetch_bht_branch_pc;
    logic                           bht_fetch_ready;
    logic [CHECKPOINT_ID_WIDTH-1:0] bht_fetch_cpbuf_id;
    logic [GHR_W-1:0]               bht_fetch_global_history;
    logic [LHR_W-1:0]               bht_fetch_local_history;

    modport master (
        output fetch_bht_branch_valid,
        output fetch_bht_branch_taken,
        output fetch_bht_branch_pc,
        input  bht_fetch_ready,
        input  bht_fetch_cpbuf_id,
        input  bht_fetch_global_history,
        input  bht_fetch_local_history
    );

    modport slave (
        input  fetch_bht_branch_valid,
        input  fetch_bht_branch_taken,
        input  fetch_bht_branch_pc,
        output bht_fetch_ready,
        output bht_fetch_cpbuf_id,
        output bht_fetch_global_history,
        output bht_fetch_local_history
    );

endinterface

// File: rtl/branch_history_tracker_commit_history_compactor.sv
// commit_history_compactor: shifts the taken bits of the valid commit slots
// into a history register, slot 0 first, so the youngest valid slot lands in bit 0.
// Invalid slots are skipped entirely. Purely combinational.
//   commit_valid : per-slot retire-a-branch flag
//   commit_taken : per-slot actual direction
//   ghr_in       : current architectural history
//   ghr_out      : history after all valid slots are shifted in
module commit_history_compactor
    import branch_history_tracker_pkg::*;
#(
    parameter int CW = COMMIT_WIDTH,
    parameter int W  = GHR_W
) (
    input  logic [CW-1:0] commit_valid,
    input  logic [CW-1:0] commit_taken,
    input  logic [W-1:0]  ghr_in,
    output logic [W-1:0]  ghr_out
);

    // stage[i] is the history after slots 0..i-1 have been considered
    logic [W-1:0] stage [CW+1];

    assign stage[0] = ghr_in;

    generate
        for (genvar gi = 0; gi < CW; gi++) begin : g_slot
            assign stage[gi+1] = commit_valid[gi] ? {stage[gi][W-2:0], commit_taken[gi]}
                                                  : stage[gi];
        end
    endgenerate

    assign ghr_out = stage[CW];

endmodule

// File: rtl/branch_history_tracker.sv
// branch_history_tracker: fetch-side speculative global/local branch history.
// Each accepted predicted branch binds a checkpoint id, pushes a snapshot of
// the pre-update histories to checkpoint_buffer and shifts in its direction.
// Execute mispredicts restore from the branch's checkpoint; commit flushes
// restore the global history from the architectural GHR.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   fetch_if (slave)          : fetch branch request / ready / id / histories
//   cpbuf_fetch_new_id(_valid): next free checkpoint id, buffer not full
//   fetch_cpbuf_data/_push    : snapshot and push strobe into checkpoint_buffer
//   exbru_bht_*               : execute-stage mispredict, actual direction, pc
//   cpbuf_exbru_data          : checkpoint of the mispredicted branch
//   commit_bht_*              : per-slot retire valid/taken, commit flush
module branch_history_tracker
    import branch_history_tracker_pkg::*;
#(
    parameter int GHR_WIDTH     = GHR_W,
    parameter int LHR_WIDTH     = LHR_W,
    parameter int LHT_SIZE      = 256,
    parameter int LHT_INDEX_LSB = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    branch_history_tracker_if.slave        fetch_if,
    input  logic [CHECKPOINT_ID_WIDTH-1:0] cpbuf_fetch_new_id,
    input  logic                           cpbuf_fetch_new_id_valid,
    output checkpoint_t                    fetch_cpbuf_data,
    output logic                           fetch_cpbuf_push,
    input  logic                           exbru_bht_mispredict,
    input  logic                           exbru_bht_taken,
    input  logic [31:0]                    exbru_bht_pc,
    input  checkpoint_t                    cpbuf_exbru_data,
    input  logic [COMMIT_WIDTH-1:0]        commit_bht_branch_valid,
    input  logic [COMMIT_WIDTH-1:0]        commit_bht_branch_taken,
    input  logic                           commit_bht_flush
);

    localparam int IDX_W = $clog2(LHT_SIZE);

    logic [GHR_WIDTH-1:0] spec_ghr_reg, spec_ghr_next;
    logic [GHR_WIDTH-1:0] arch_ghr_reg, arch_ghr_next;
    logic [LHR_WIDTH-1:0] lht_reg [LHT_SIZE];

    logic [IDX_W-1:0]     fetch_idx, exbru_idx;
    logic [LHR_WIDTH-1:0] lht_rd_data;
    logic                 blocked;
    logic                 accept;
    logic                 lht_we;
    logic [IDX_W-1:0]     lht_waddr;
    logic [LHR_WIDTH-1:0] lht_wdata;

    // Index is a plain bit-slice of the pc, so larger pcs alias by truncation
    assign fetch_idx = fetch_if.fetch_bht_branch_pc[LHT_INDEX_LSB +: IDX_W];
    assign exbru_idx = exbru_bht_pc[LHT_INDEX_LSB +: IDX_W];

    assign lht_rd_data = lht_reg[fetch_idx];

    // Anything that will rewrite history this cycle stalls fetch; rst folded in
    // so the handshake drops the moment reset asserts
    assign blocked = ~cpbuf_fetch_new_id_valid | exbru_bht_mispredict | commit_bht_flush | ~rst;
    assign accept  = fetch_if.fetch_bht_branch_valid & ~blocked;

    assign fetch_if.bht_fetch_ready          = ~blocked;
    assign fetch_if.bht_fetch_cpbuf_id       = rst ? cpbuf_fetch_new_id : '0;
    assign fetch_if.bht_fetch_global_history = spec_ghr_reg;
    assign fetch_if.bht_fetch_local_history  = lht_rd_data;

    assign fetch_cpbuf_push = accept;

    always_comb begin
        fetch_cpbuf_data                           = '0;
        fetch_cpbuf_data.global_history            = spec_ghr_reg;
        fetch_cpbuf_data.local_history             = lht_rd_data;
        fetch_cpbuf_data.rat_phy_map_table_valid   = '0;
        fetch_cpbuf_data.rat_phy_map_table_visible = '0;
    end

    commit_history_compactor #(
        .CW (COMMIT_WIDTH),
        .W  (GHR_WIDTH)
    ) u_compactor (
        .commit_valid (commit_bht_branch_valid),
        .commit_taken (commit_bht_branch_taken),
        .ghr_in       (arch_ghr_reg),
        .ghr_out      (arch_ghr_next)
    );

    // Flush restores from arch_ghr_next so same-cycle commits are not lost
    always_comb begin
        spec_ghr_next = spec_ghr_reg;
        if (commit_bht_flush) begin
            spec_ghr_next = arch_ghr_next;
        end else if (exbru_bht_mispredict) begin
            spec_ghr_next = {cpbuf_exbru_data.global_history[GHR_WIDTH-2:0], exbru_bht_taken};
        end else if (accept) begin
            spec_ghr_next = {spec_ghr_reg[GHR_WIDTH-2:0], fetch_if.fetch_bht_branch_taken};
        end
    end

    // Single LHT write port: mispredict repair takes it over fetch; a flush
    // leaves the table alone
    always_comb begin
        lht_we    = 1'b0;
        lht_waddr = fetch_idx;
        lht_wdata = {lht_rd_data[LHR_WIDTH-2:0], fetch_if.fetch_bht_branch_taken};
        if (!commit_bht_flush) begin
            if (exbru_bht_mispredict) begin
                lht_we    = 1'b1;
                lht_waddr = exbru_idx;
                lht_wdata = {cpbuf_exbru_data.local_history[LHR_WIDTH-2:0], exbru_bht_taken};
            end else if (accept) begin
                lht_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_ghr_reg <= '0;
            arch_ghr_reg <= '0;
        end else begin
            spec_ghr_reg <= spec_ghr_next;
            arch_ghr_reg <= arch_ghr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LHT_SIZE; i++) begin
                lht_reg[i] <= '0;
            end
        end else if (lht_we) begin
            lht_reg[lht_waddr] <= lht_wdata;
        end
    end

endmodule

// File: tb/tb_branch_history_tracker.sv
module tb_branch_history_tracker;
    import branch_history_tracker_pkg::*;

    logic                           clk;
    logic                           rst;
    logic [CHECKPOINT_ID_WIDTH-1:0] cpbuf_fetch_new_id;
    logic                           cpbuf_fetch_new_id_valid;
    checkpoint_t                    fetch_cpbuf_data;
    logic                           fetch_cpbuf_push;
    logic                           exbru_bht_mispredict;
    logic                           exbru_bht_taken;
    logic [31:0]                    exbru_bht_pc;
    checkpoint_t                    cpbuf_exbru_data;
    logic [COMMIT_WIDTH-1:0]        commit_bht_branch_valid;
    logic [COMMIT_WIDTH-1:0]        commit_bht_branch_taken;
    logic                           commit_bht_flush;

    int n_vec = 0;
    int n_err = 0;

    branch_history_tracker_if bif ();

    branch_history_tracker dut (
        .clk                      (clk),
        .rst                      (rst),
        .fetch_if                 (bif),
        .cpbuf_fetch_new_id       (cpbuf_fetch_new_id),
        .cpbuf_fetch_new_id_valid (cpbuf_fetch_new_id_valid),
        .fetch_cpbuf_data         (fetch_cpbuf_data),
        .fetch_cpbuf_push         (fetch_cpbuf_push),
        .exbru_bht_mispredict     (exbru_bht_mispredict),
        .exbru_bht_taken          (exbru_bht_taken),
        .exbru_bht_pc             (exbru_bht_pc),
        .cpbuf_exbru_data         (cpbuf_exbru_data),
        .commit_bht_branch_valid  (commit_bht_branch_valid),
        .commit_bht_branch_taken  (commit_bht_branch_taken),
        .commit_bht_flush         (commit_bht_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic t, input logic [31:0] pc);
        bif.fetch_bht_branch_valid = v;
        bif.fetch_bht_branch_taken = t;
        bif.fetch_bht_branch_pc    = pc;
    endtask

    initial begin
        rst                      = 1'b0;
        fetch(1'b1, 1'b1, 32'h100);
        cpbuf_fetch_new_id       = 3'd3;
        cpbuf_fetch_new_id_valid = 1'b1;
        exbru_bht_mispredict     = 1'b0;
        exbru_bht_taken          = 1'b0;
        exbru_bht_pc             = 32'h0;
        cpbuf_exbru_data         = '0;
        commit_bht_branch_valid  = '0;
        commit_bht_branch_taken  = '0;
        commit_bht_flush         = 1'b0;

        // Reset state
        #2;
        check("rst_ready", 32'(bif.bht_fetch_ready), 32'h0);
        check("rst_push",  32'(fetch_cpbuf_push), 32'h0);
        check("rst_id",    32'(bif.bht_fetch_cpbuf_id), 32'h0);
        check("rst_ghr",   32'(bif.bht_fetch_global_history), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Branch T (pc 0x100 -> idx 0x40), id 0
        fetch(1'b1, 1'b1, 32'h100);
        cpbuf_fetch_new_id = 3'd0;
        #1;
        check("b0_ready", 32'(bif.bht_fetch_ready), 32'h1);
        check("b0_push",  32'(fetch_cpbuf_push), 32'h1);
        check("b0_id",    32'(bif.bht_fetch_cpbuf_id), 32'h0);
        check("b0_ghr",   32'(fetch_cpbuf_data.global_history), 32'h0);
        check("b0_lhr",   32'(fetch_cpbuf_data.local_history), 32'h0);
        check("b0_rat",   32'(fetch_cpbuf_data.rat_phy_map_table_valid), 32'h0);
        cycle();

        // Branch N, same pc, id 1
        fetch(1'b1, 1'b0, 32'h100);
        cpbuf_fetch_new_id = 3'd1;
        #1;
        check("b1_push", 32'(fetch_cpbuf_push), 32'h1);
        check("b1_id",   32'(bif.bht_fetch_cpbuf_id), 32'h1);
        check("b1_ghr",  32'(fetch_cpbuf_data.global_history), 32'h1);
        check("b1_lhr",  32'(fetch_cpbuf_data.local_history), 32'h1);
        cycle();

        // Branch T, pc 0x200 (idx 0x80), id 2
        fetch(1'b1, 1'b1, 32'h200);
        cpbuf_fetch_new_id = 3'd2;
        #1;
        check("b2_ghr", 32'(fetch_cpbuf_data.global_history), 32'h2);
        check("b2_lhr", 32'(fetch_cpbuf_data.local_history), 32'h0);
        cycle();

        // Idle: history settled
        fetch(1'b0, 1'b0, 32'h100);
        #1;
        check("idle_ready", 32'(bif.bht_fetch_ready), 32'h1);
        check("idle_push",  32'(fetch_cpbuf_push), 32'h0);
        check("ghr_after3", 32'(bif.bht_fetch_global_history), 32'h5);
        check("lht_40",     32'(bif.bht_fetch_local_history), 32'h2);
        fetch(1'b0, 1'b0, 32'h500);   // aliases idx 0x40
        #1;
        check("lht_wrap",   32'(bif.bht_fetch_local_history), 32'h2);

        // Checkpoint buffer full
        fetch(1'b1, 1'b1, 32'h100);
        cpbuf_fetch_new_id_valid = 1'b0;
        #1;
        check("full_ready", 32'(bif.bht_fetch_ready), 32'h0);
        check("full_push",  32'(fetch_cpbuf_push), 32'h0);
        cycle();
        cpbuf_fetch_new_id_valid = 1'b1;
        fetch(1'b0, 1'b0, 32'h100);
        #1;
        check("full_ghr", 32'(bif.bht_fetch_global_history), 32'h5);

        // Mispredict with same-cycle fetch branch
        fetch(1'b1, 1'b0, 32'h100);
        exbru_bht_mispredict            = 1'b1;
        exbru_bht_taken                 = 1'b1;
        exbru_bht_pc                    = 32'h300;   // idx 0xC0
        cpbuf_exbru_data.global_history = 16'h0002;
        cpbuf_exbru_data.local_history  = 16'h1234;
        #1;
        check("mp_push",  32'(fetch_cpbuf_push), 32'h0);
        check("mp_ready", 32'(bif.bht_fetch_ready), 32'h0);
        cycle();
        exbru_bht_mispredict = 1'b0;
        fetch(1'b0, 1'b0, 32'h300);
        #1;
        check("mp_ghr",   32'(bif.bht_fetch_global_history), 32'h5);
        check("mp_lht",   32'(bif.bht_fetch_local_history), 32'h2469);
        fetch(1'b0, 1'b0, 32'h100);
        #1;
        check("mp_lht40", 32'(bif.bht_fetch_local_history), 32'h2);

        // Second mispredict, not-taken, distinct checkpoint
        exbru_bht_mispredict            = 1'b1;
        exbru_bht_taken                 = 1'b0;
        exbru_bht_pc                    = 32'h200;   // idx 0x80
        cpbuf_exbru_data.global_history = 16'h00F0;
        cpbuf_exbru_data.local_history  = 16'h8001;
        cycle();
        exbru_bht_mispredict = 1'b0;
        fetch(1'b0, 1'b0, 32'h200);
        #1;
        check("mp2_ghr", 32'(bif.bht_fetch_global_history), 32'h1E0);
        check("mp2_lht", 32'(bif.bht_fetch_local_history), 32'h0002);

        // Commit 1111/1011 with flush in the same cycle
        fetch(1'b1, 1'b1, 32'h100);
        commit_bht_branch_valid = 4'b1111;
        commit_bht_branch_taken = 4'b1011;
        commit_bht_flush        = 1'b1;
        #1;
        check("fl_ready", 32'(bif.bht_fetch_ready), 32'h0);
        check("fl_push",  32'(fetch_cpbuf_push), 32'h0);
        cycle();
        commit_bht_branch_valid = '0;
        commit_bht_flush        = 1'b0;
        fetch(1'b0, 1'b0, 32'h100);
        #1;
        check("fl_ghr",   32'(bif.bht_fetch_global_history), 32'hD);
        check("fl_lht40", 32'(bif.bht_fetch_local_history), 32'h2);

        // Commit with a skipped slot: arch 0xD -> 0x35, spec untouched
        commit_bht_branch_valid = 4'b1010;
        commit_bht_branch_taken = 4'b1000;
        cycle();
        commit_bht_branch_valid = '0;
        commit_bht_branch_taken = '0;
        #1;
        check("cm_spec", 32'(bif.bht_fetch_global_history), 32'hD);

        // Flush and mispredict together: arch wins, LHT untouched
        commit_bht_flush                = 1'b1;
        exbru_bht_mispredict            = 1'b1;
        exbru_bht_taken                 = 1'b0;
        exbru_bht_pc                    = 32'h300;
        cpbuf_exbru_data.global_history = 16'h0AAA;
        cpbuf_exbru_data.local_history  = 16'hFFFF;
        cycle();
        commit_bht_flush     = 1'b0;
        exbru_bht_mispredict = 1'b0;
        fetch(1'b0, 1'b0, 32'h300);
        #1;
        check("flmp_ghr", 32'(bif.bht_fetch_global_history), 32'h35);
        check("flmp_lht", 32'(bif.bht_fetch_local_history), 32'h2469);

        // Asynchronous reset mid-stream
        fetch(1'b1, 1'b1, 32'h300);
        #1;
        check("pre_rst_push", 32'(fetch_cpbuf_push), 32'h1);
        rst = 1'b0;
        #1;
        check("ar_push",  32'(fetch_cpbuf_push), 32'h0);
        check("ar_ready", 32'(bif.bht_fetch_ready), 32'h0);
        check("ar_ghr",   32'(bif.bht_fetch_global_history), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        fetch(1'b0, 1'b0, 32'h300);
        #1;
        check("post_lht_c0", 32'(bif.bht_fetch_local_history), 32'h0);
        fetch(1'b0, 1'b0, 32'h100);
        #1;
        check("post_lht_40", 32'(bif.bht_fetch_local_history), 32'h0);
        commit_bht_flush = 1'b1;
        cycle();
        commit_bht_flush = 1'b0;
        #1;
        check("post_arch", 32'(bif.bht_fetch_global_history), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
